reg_bank_snap: RTL and testbench

- Parametrised multi-channel successor to the two-channel data/status register block.
- Provides NUM_CH channels. Each channel has a DATA register, a SNAP register and a STAT register.
  - DATA is byte-writable.
  - SNAP captures DATA on command.
  - STAT holds sticky, write-1-to-clear event flags.
- Separate read and write ports; registered read with a valid/error response; level interrupt output.
- Sits behind the bus-to-register adapter as a peripheral register slave.

---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/reg_bank_snap_if.sv | 27 ++
 rtl/reg_bank_chan.sv | 82 ++++++++
 rtl/reg_bank_snap.sv | 120 ++++++++++++
 tb/tb_reg_bank_snap.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants for the snapshot register bank: register offsets and STAT bit positions.
package reg_bank_pkg;

   localparam logic [3:0] OFF_DATA = 4'h0;
   localparam logic [3:0] OFF_SNAP = 4'h4;
   localparam logic [3:0] OFF_STAT = 4'h8;
   localparam logic [3:0] OFF_WCNT = 4'hC;

   localparam int unsigned SNAP_VALID = 0;
   localparam int unsigned OVERRUN    = 1;
   localparam int unsigned DIRTY      = 2;
   localparam int unsigned STAT_W     = 3;

endpackage

// File: rtl/reg_bank_snap_if.sv
// Register-slave port bundle: split write/read request ports, registered responses and irq.
interface reg_bank_snap_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
);
   logic                  wr_en;
   logic [ADDR_W-1:0]     waddr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  werr;
   logic                  rd_en;
   logic [ADDR_W-1:0]     raddr;
   logic [DATA_W-1:0]     rdata;
   logic                  rvalid;
   logic                  rerr;
   logic                  irq;

   modport master (
      output wr_en, waddr, wdata, wstrb, rd_en, raddr,
      input  werr, rdata, rvalid, rerr, irq
   );

   modport slave (
      input  wr_en, waddr, wdata, wstrb, rd_en, raddr,
      output werr, rdata, rvalid, rerr, irq
   );
endinterface

// File: rtl/reg_bank_chan.sv
// One channel: byte-writable DATA, SNAP capture, sticky STAT/dirty and, with
// REG_BANK_WCNT_EN defined, a saturating 16-bit DATA-write counter.
module reg_bank_chan
   import reg_bank_pkg::*;
#(
   parameter int unsigned         DATA_W   = 32,
   parameter logic [DATA_W-1:0]   DATA_RST = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_data,
   input  logic                wr_snap,
   input  logic                wr_stat,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   data,
   output logic [DATA_W-1:0]   snap,
   output logic [STAT_W-1:0]   stat
`ifdef REG_BANK_WCNT_EN
   ,
   input  logic                wr_wcnt,
   output logic [15:0]         wcnt
`endif
);

   logic [DATA_W-1:0] data_q, data_d, snap_q;
   logic              snap_valid_q, overrun_q, dirty_q;

   always_comb begin
      data_d = data_q;
      for (int unsigned b = 0; b < DATA_W / 8; b++) begin
         if (wstrb[b]) data_d[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   // Write strobes are mutually exclusive (one write address per cycle).
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q       <= DATA_RST;
         snap_q       <= DATA_RST;
         snap_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         dirty_q      <= 1'b0;
      end else begin
         if (wr_data) begin
            data_q  <= data_d;
            dirty_q <= 1'b1;
            if (dirty_q) overrun_q <= 1'b1;
         end
         if (wr_snap) begin
            snap_q       <= data_q;
            snap_valid_q <= 1'b1;
            dirty_q      <= 1'b0;
         end
         if (wr_stat) begin
            if (wdata[SNAP_VALID]) snap_valid_q <= 1'b0;
            if (wdata[OVERRUN])    overrun_q    <= 1'b0;
         end
      end
   end

   assign data = data_q;
   assign snap = snap_q;
   assign stat = {dirty_q, overrun_q, snap_valid_q};

`ifdef REG_BANK_WCNT_EN
   logic [15:0] wcnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= 16'h0000;
      end else if (wr_wcnt) begin
         wcnt_q <= 16'h0000;
      end else if (wr_data && (wcnt_q != 16'hFFFF)) begin
         wcnt_q <= wcnt_q + 16'h0001;
      end
   end

   assign wcnt = wcnt_q;
`endif

endmodule

// File: rtl/reg_bank_snap.sv
// Multi-channel DATA/SNAP/STAT register bank: address decode, read mux, registered
// read/error response and irq. Optional WCNT registers via REG_BANK_WCNT_EN.
module reg_bank_snap
   import reg_bank_pkg::*;
#(
   parameter int unsigned         NUM_CH   = 4,
   parameter int unsigned         DATA_W   = 32,
   parameter int unsigned         ADDR_W   = 10,
   parameter logic [DATA_W-1:0]   DATA_RST = '0
) (
   input logic            clk,
   input logic            rst,
   reg_bank_snap_if.slave bus
);

   localparam int unsigned CH_W = ADDR_W - 4;

   function automatic logic addr_mapped(logic [ADDR_W-1:0] a);
      logic ok;
      ok = (32'(a[ADDR_W-1:4]) < NUM_CH) && (a[1:0] == 2'b00);
`ifndef REG_BANK_WCNT_EN
      if (a[3:0] == OFF_WCNT) ok = 1'b0;
`endif
      return ok;
   endfunction

   logic [CH_W-1:0]   wch, rch;
   logic [3:0]        woff, roff;
   logic              wmap, rmap;
   logic [NUM_CH-1:0] wr_data_s, wr_snap_s, wr_stat_s, wr_wcnt_s;
   logic [DATA_W-1:0] data_v [NUM_CH];
   logic [DATA_W-1:0] snap_v [NUM_CH];
   logic [STAT_W-1:0] stat_v [NUM_CH];
   logic [15:0]       wcnt_v [NUM_CH];
   logic [DATA_W-1:0] rd_val;
   logic              any_overrun;

   assign wch  = bus.waddr[ADDR_W-1:4];
   assign woff = bus.waddr[3:0];
   assign rch  = bus.raddr[ADDR_W-1:4];
   assign roff = bus.raddr[3:0];
   assign wmap = addr_mapped(bus.waddr);
   assign rmap = addr_mapped(bus.raddr);

   always_comb begin
      wr_data_s = '0;
      wr_snap_s = '0;
      wr_stat_s = '0;
      wr_wcnt_s = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (bus.wr_en && wmap && (32'(wch) == i)) begin
            wr_data_s[i] = (woff == OFF_DATA);
            wr_snap_s[i] = (woff == OFF_SNAP);
            wr_stat_s[i] = (woff == OFF_STAT);
            wr_wcnt_s[i] = (woff == OFF_WCNT);
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      reg_bank_chan #(
         .DATA_W   (DATA_W),
         .DATA_RST (DATA_RST)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .wr_data (wr_data_s[g]),
         .wr_snap (wr_snap_s[g]),
         .wr_stat (wr_stat_s[g]),
         .wdata   (bus.wdata),
         .wstrb   (bus.wstrb),
         .data    (data_v[g]),
         .snap    (snap_v[g]),
         .stat    (stat_v[g])
`ifdef REG_BANK_WCNT_EN
         ,
         .wr_wcnt (wr_wcnt_s[g]),
         .wcnt    (wcnt_v[g])
`endif
      );
`ifndef REG_BANK_WCNT_EN
      assign wcnt_v[g] = 16'h0000;
`endif
   end

   // Reads sample current register state, so a same-cycle write is not yet visible.
   always_comb begin
      rd_val      = '0;
      any_overrun = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         any_overrun = any_overrun | stat_v[i][OVERRUN];
         if (32'(rch) == i) begin
            case (roff)
               OFF_DATA: rd_val = data_v[i];
               OFF_SNAP: rd_val = snap_v[i];
               OFF_STAT: rd_val = DATA_W'(stat_v[i]);
               OFF_WCNT: rd_val = DATA_W'(wcnt_v[i]);
               default:  rd_val = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rdata  <= '0;
         bus.rvalid <= 1'b0;
         bus.rerr   <= 1'b0;
         bus.werr   <= 1'b0;
         bus.irq    <= 1'b0;
      end else begin
         bus.rvalid <= bus.rd_en;
         bus.rerr   <= bus.rd_en && !rmap;
         bus.rdata  <= (bus.rd_en && rmap) ? rd_val : '0;
         bus.werr   <= bus.wr_en && !wmap;
         bus.irq    <= any_overrun;
      end
   end

endmodule

// File: tb/tb_reg_bank_snap.sv
// Directed self-checking bench for reg_bank_snap (NUM_CH=4, DATA_W=32, ADDR_W=10).
module tb_reg_bank_snap;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   reg_bank_snap_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   reg_bank_snap #(
      .NUM_CH   (4),
      .DATA_W   (32),
      .ADDR_W   (10),
      .DATA_RST (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.waddr = a;
      bus.wdata = d;
      bus.wstrb = s;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic do_read(input logic [9:0] a, output logic [31:0] d, output logic v,
                          output logic e);
      @(negedge clk);
      bus.rd_en = 1'b1;
      bus.raddr = a;
      @(negedge clk);
      bus.rd_en = 1'b0;
      d = bus.rdata;
      v = bus.rvalid;
      e = bus.rerr;
   endtask

   initial begin
      logic [31:0] d;
      logic        v, e;
      bus.wr_en = 1'b0;
      bus.waddr = '0;
      bus.wdata = '0;
      bus.wstrb = '0;
      bus.rd_en = 1'b0;
      bus.raddr = '0;

      repeat (3) @(negedge clk);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_irq", 32'(bus.irq), 32'd0);
      check("rst_werr", 32'(bus.werr), 32'd0);
      rst = 1'b0;

      do_read(10'h000, d, v, e);
      check("ch0_data_rst", d, 32'h0000_0000);
      check("ch0_rvalid", 32'(v), 32'd1);
      check("ch0_rerr", 32'(e), 32'd0);
      check("ch0_irq", 32'(bus.irq), 32'd0);
      @(negedge clk);
      check("idle_rvalid", 32'(bus.rvalid), 32'd0);

      // Byte strobes, then snapshot
      do_write(10'h020, 32'hAABB_CCDD, 4'b0101);
      check("ch2_werr", 32'(bus.werr), 32'd0);
      do_read(10'h020, d, v, e);
      check("ch2_data", d, 32'h00BB_00DD);
      do_write(10'h024, 32'hFFFF_FFFF, 4'b0000);
      do_read(10'h024, d, v, e);
      check("ch2_snap", d, 32'h00BB_00DD);
      do_read(10'h028, d, v, e);
      check("ch2_stat", d, 32'h0000_0001);

      // Overrun and irq timing
      do_write(10'h010, 32'h1111_1111, 4'b1111);
      do_read(10'h018, d, v, e);
      check("ch1_stat_dirty", d, 32'h0000_0004);
      do_write(10'h010, 32'h2222_2222, 4'b1111);
      check("irq_not_yet", 32'(bus.irq), 32'd0);
      @(negedge clk);
      check("irq_rise", 32'(bus.irq), 32'd1);
      do_read(10'h018, d, v, e);
      check("ch1_stat_ovr", d, 32'h0000_0006);
      do_write(10'h018, 32'h0000_0002, 4'b1111);
      check("irq_hold", 32'(bus.irq), 32'd1);
      @(negedge clk);
      check("irq_fall", 32'(bus.irq), 32'd0);
      do_read(10'h018, d, v, e);
      check("ch1_stat_clr", d, 32'h0000_0004);

      // Same-cycle read and write of ch3 DATA
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.waddr = 10'h030;
      bus.wdata = 32'h1234_5678;
      bus.wstrb = 4'b1111;
      bus.rd_en = 1'b1;
      bus.raddr = 10'h030;
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      check("ch3_old", bus.rdata, 32'h0000_0000);
      check("ch3_old_v", 32'(bus.rvalid), 32'd1);
      do_read(10'h030, d, v, e);
      check("ch3_new", d, 32'h1234_5678);

      // Unmapped and misaligned accesses
      do_read(10'h040, d, v, e);
      check("unm_rd_rerr", 32'(e), 32'd1);
      check("unm_rd_data", d, 32'h0000_0000);
      do_write(10'h040, 32'hDEAD_BEEF, 4'b1111);
      check("unm_wr_werr", 32'(bus.werr), 32'd1);
      @(negedge clk);
      check("werr_pulse", 32'(bus.werr), 32'd0);
      do_write(10'h001, 32'hCAFE_F00D, 4'b1111);
      check("mis_wr_werr", 32'(bus.werr), 32'd1);
      do_read(10'h002, d, v, e);
      check("mis_rd_rerr", 32'(e), 32'd1);
      check("mis_rd_data", d, 32'h0000_0000);
      do_read(10'h000, d, v, e);
      check("ch0_untouched", d, 32'h0000_0000);
      do_read(10'h008, d, v, e);
      check("ch0_stat_clean", d, 32'h0000_0000);

`ifdef REG_BANK_WCNT_EN
      do_write(10'h000, 32'h0000_0001, 4'b1111);
      do_write(10'h000, 32'h0000_0002, 4'b1111);
      do_write(10'h000, 32'h0000_0003, 4'b1111);
      do_read(10'h00C, d, v, e);
      check("wcnt_3", d, 32'h0000_0003);
      check("wcnt_rerr", 32'(e), 32'd0);
      do_write(10'h00C, 32'h0000_0000, 4'b0000);
      check("wcnt_werr", 32'(bus.werr), 32'd0);
      do_read(10'h00C, d, v, e);
      check("wcnt_clr", d, 32'h0000_0000);
`else
      do_read(10'h00C, d, v, e);
      check("wcnt_off_rerr", 32'(e), 32'd1);
      check("wcnt_off_data", d, 32'h0000_0000);
      do_write(10'h00C, 32'h0000_0000, 4'b1111);
      check("wcnt_off_werr", 32'(bus.werr), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
